// File: rtl/fpu_align_pkg.sv
// Shared constants and state encoding for the
// single-precision add/sub alignment stage.
package fpu_align_pkg;

  localparam int ExponentSize = 8;
  localparam int MantissaSize = 23;
  localparam int AlignWidth   = MantissaSize + 4;
  localparam int MaxShift     = AlignWidth;
  localparam int RemWidth     = $clog2(MaxShift + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/align_exp_compare.sv
// Exponent compare: effective exponents, swap,
// clamped shift distance and equal flag.
module align_exp_compare
  import fpu_align_pkg::*;
(
  input  logic [ExponentSize+MantissaSize:0] i_op_a,
  input  logic [ExponentSize+MantissaSize:0] i_op_b,
  output logic [ExponentSize-1:0]            o_exp_a_eff,
  output logic [ExponentSize-1:0]            o_exp_b_eff,
  output logic                               o_swap,
  output logic                               o_equal,
  output logic [RemWidth-1:0]                o_shift
);

  logic [ExponentSize-1:0] w_ea;
  logic [ExponentSize-1:0] w_eb;
  logic [ExponentSize-1:0] w_diff;

  assign w_ea = i_op_a[MantissaSize +: ExponentSize];
  assign w_eb = i_op_b[MantissaSize +: ExponentSize];

  // A zero exponent is a denormal and behaves as exponent 1.
  assign o_exp_a_eff = (w_ea == '0) ? ExponentSize'(1) : w_ea;
  assign o_exp_b_eff = (w_eb == '0) ? ExponentSize'(1) : w_eb;

  assign o_swap  = o_exp_b_eff > o_exp_a_eff;
  assign o_equal = o_exp_b_eff == o_exp_a_eff;

  assign w_diff = o_swap ? (o_exp_b_eff - o_exp_a_eff)
                         : (o_exp_a_eff - o_exp_b_eff);

  // Beyond MaxShift every bit lands in sticky anyway.
  assign o_shift = (w_diff > ExponentSize'(MaxShift))
                 ? RemWidth'(MaxShift)
                 : w_diff[RemWidth-1:0];

endmodule

// File: rtl/align_shift_sequencer.sv
// Multi-cycle operand alignment with sticky
// collection and valid/ready handshakes.
module align_shift_sequencer #(
  parameter int ExponentSize = fpu_align_pkg::ExponentSize,
  parameter int MantissaSize = fpu_align_pkg::MantissaSize,
  parameter int MaxStep      = 8
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             InValid,
  output logic                             InReady,
  input  logic [ExponentSize+MantissaSize:0] OpA,
  input  logic [ExponentSize+MantissaSize:0] OpB,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic [MantissaSize+3:0]          AlignedBig,
  output logic [MantissaSize+3:0]          AlignedSmall,
  output logic [ExponentSize-1:0]          ExpOut,
  output logic                             OrderFlag,
  output logic                             ZeroFlag,
  output logic                             Busy
);

  import fpu_align_pkg::*;

  localparam int AW = MantissaSize + 4;

  state_t r_state;
  state_t w_next;

  logic [RemWidth-1:0]     r_rem;
  logic [RemWidth-1:0]     w_shift;
  logic [RemWidth-1:0]     w_step;
  logic [RemWidth-1:0]     w_rem_nxt;
  logic [ExponentSize-1:0] w_exp_a;
  logic [ExponentSize-1:0] w_exp_b;
  logic                    w_swap;
  logic                    w_equal;
  logic                    w_accept;
  logic                    w_lost;
  logic [AW-1:0]           w_sig_a;
  logic [AW-1:0]           w_sig_b;
  logic [AW-1:0]           w_shifted;
  logic [AW-1:0]           w_mask;
  logic [AW-1:0]           w_small_nxt;
  logic [AW-1:0]           r_big;
  logic [AW-1:0]           r_small;
  logic [ExponentSize-1:0] r_exp;
  logic                    r_order;
  logic                    r_zero;
  logic                    r_out_valid;
  logic                    r_busy;

  align_exp_compare u_cmp (
    .i_op_a      (OpA),
    .i_op_b      (OpB),
    .o_exp_a_eff (w_exp_a),
    .o_exp_b_eff (w_exp_b),
    .o_swap      (w_swap),
    .o_equal     (w_equal),
    .o_shift     (w_shift)
  );

  assign w_sig_a = {|OpA[MantissaSize +: ExponentSize],
                    OpA[MantissaSize-1:0], 3'b000};
  assign w_sig_b = {|OpB[MantissaSize +: ExponentSize],
                    OpB[MantissaSize-1:0], 3'b000};

  assign InReady  = (r_state == IDLE);
  assign w_accept = InReady && InValid;

  assign w_step = (r_rem > RemWidth'(MaxStep))
                ? RemWidth'(MaxStep) : r_rem;
  assign w_rem_nxt = r_rem - w_step;

  assign w_shifted   = r_small >> w_step;
  assign w_mask      = ~({AW{1'b1}} << w_step);
  assign w_lost      = |(r_small & w_mask);
  assign w_small_nxt = {w_shifted[AW-1:1],
                        w_shifted[0] | w_lost | r_small[0]};

  // Next-state decode for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (InValid)
               w_next = (w_shift == '0) ? DONE : SHIFT;
      SHIFT: if (w_rem_nxt == '0) w_next = DONE;
      DONE:  if (OutReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Registered status flags, derived from the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
    end
  end

  // Operand capture on accept, then stepwise shift with sticky.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_big   <= '0;
      r_small <= '0;
      r_exp   <= '0;
      r_order <= 1'b0;
      r_zero  <= 1'b0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_big   <= w_swap ? w_sig_b : w_sig_a;
      r_small <= w_swap ? w_sig_a : w_sig_b;
      r_exp   <= w_swap ? w_exp_b : w_exp_a;
      r_order <= ~w_swap;
      r_zero  <= w_equal;
      r_rem   <= w_shift;
    end else if (r_state == SHIFT) begin
      r_small <= w_small_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  assign OutValid     = r_out_valid;
  assign Busy         = r_busy;
  assign AlignedBig   = r_big;
  assign AlignedSmall = r_small;
  assign ExpOut       = r_exp;
  assign OrderFlag    = r_order;
  assign ZeroFlag     = r_zero;

endmodule

// File: doc/align_shift_sequencer.md
# align_shift_sequencer

Multi-cycle alignment controller for the single-precision add/sub path. It accepts an operand pair over a valid/ready handshake and orders the operands by exponent. It then right-shifts the smaller significand by the clamped exponent difference, at most `MaxStep` bits per cycle, collecting the shifted-out bits into a sticky bit. The aligned pair, the result exponent and the order flag go to the significand adder over a second valid/ready handshake.

## Interface
- `ExponentSize`, 8, exponent width.
- `MantissaSize`, 23, stored fraction width.
- `MaxStep`, 8, maximum right shift per cycle (1..27).
- `Clk` in 1: clock. All state changes on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `InValid` in 1: operand pair valid.
- `InReady` out 1: block can accept an operand pair.
- `OpA` in 32: IEEE-754 single operand A.
- `OpB` in 32: IEEE-754 single operand B.
- `OutValid` out 1: aligned result valid.
- `OutReady` in 1: consumer accepts the result.
- `AlignedBig` out 27: larger-exponent significand, formatted {hidden, fraction, G, R, S}.
- `AlignedSmall` out 27: shifted smaller significand, with S as the sticky OR of all bits shifted out.
- `ExpOut` out 8: larger effective exponent.
- `OrderFlag` out 1: 1 when ExpA ≥ ExpB (no swap); 0 when B is larger.
- `ZeroFlag` out 1: 1 when the effective exponents are equal.
- `Busy` out 1: state is not IDLE.

## Operation
- **States:**
  - IDLE: `InReady`=1.
  - SHIFT: alignment in progress.
  - DONE: `OutValid`=1.
- **Operand unpacking:**
  - Effective exponent = max(exp, 1).
  - Hidden bit = |exp, so a zero exponent gives a denormal with hidden bit 0.
  - 27-bit significand = {hidden, fraction, 3'b000}.
- **Special operands:** Inf/NaN get no special handling and pass through as ordinary values. Special cases are handled upstream.
- **Ordering:**
  - If ExpB > ExpA, the operands swap and `OrderFlag`=0.
  - Equal exponents do not swap.
  - Mantissas are not compared.
- **Shift amount:**
  - D = ExpBig − ExpSmall (8-bit, unsigned).
  - Remaining = min(D, 27); a clamped shift moves every bit into sticky.
- **Accept** (IDLE ∧ `InValid`):
  - Register Big, Small, `ExpOut`, `OrderFlag` and `ZeroFlag`, and load Remaining.
  - Next state is DONE if Remaining=0, else SHIFT.
- **SHIFT, each cycle:**
  - step = min(Remaining, `MaxStep`).
  - Small ← (Small >> step), with bit 0 ORed with the OR of the bits shifted out and with the old bit 0.
  - Remaining ← Remaining − step.
  - Go to DONE when the new Remaining is 0.
- **DONE:**
  - Outputs held stable while `OutReady`=0.
  - `OutValid` ∧ `OutReady` → IDLE.
- **No overlap:** `InReady`=0 in SHIFT and DONE, and `InValid` is ignored there.
- **Reset:**
  - Any state → IDLE on the next edge.
  - Remaining cleared; `AlignedBig`, `AlignedSmall`, `ExpOut`, `OrderFlag`, `ZeroFlag`, `OutValid` and `Busy` all 0.
  - `InReady`=1, since it is decoded as state==IDLE.
  - A reset mid-SHIFT or mid-DONE discards the operation silently.

## Timing
- **Latency:** with the accept on edge k, `OutValid` rises at edge k + ceil(Dc/`MaxStep`), where Dc = min(D, 27).
  - Dc=0: edge k.
  - Dc=27 with `MaxStep`=8: edge k+4.
- **Output return:** a DONE handshake at edge m puts `InReady`=1 from edge m. The earliest next accept is edge m+1.
- **Throughput:** one operation per (2 + ceil(Dc/`MaxStep`)) cycles, minimum.
- **Output registering:** `OutValid`, `Busy` and the data outputs are registered. `InReady` is decoded from state.

## Structure
- **Package `fpu_align_pkg`:**
  - Constants `ExponentSize`, `MantissaSize`, `AlignWidth`=`MantissaSize`+4, `MaxShift`=27.
  - The state encoding IDLE/SHIFT/DONE.
- **Sub-module `align_exp_compare`** (combinational):
  - Takes both operands.
  - Produces the effective exponents, swap, clamped shift and equal flag.
- **Top level:** the FSM, shift/sticky datapath and handshake logic.

## Test plan
- **Equal exponents, no shift:** `OpA`=0x3F800000, `OpB`=0x3FC00000 → `OutValid` at accept edge.
  - `AlignedBig`=27'h4000000, `AlignedSmall`=27'h6000000.
  - `ExpOut`=127, `OrderFlag`=1, `ZeroFlag`=1.
- **Swap:** `OpA`=0x3F800000, `OpB`=0x41000000 → `OutValid` at k+1.
  - `OrderFlag`=0, `ExpOut`=130.
  - `AlignedBig`=27'h4000000, `AlignedSmall`=27'h0800000.
- **Sticky:** `OpA`=0x44000000, `OpB`=0x3F800001, D=9 → two SHIFT cycles, `OutValid` at k+2.
  - `AlignedSmall`=27'h0020001.
- **Clamp:** `OpA`=0x53800000, `OpB`=0x3F800000, D=40 → `OutValid` at k+4.
  - `AlignedSmall`=27'h0000001, `ExpOut`=167.
- **Backpressure:** hold `OutReady`=0 for 3 cycles in DONE while pulsing `InValid`.
  - Outputs stable, `InReady`=0, no accept.
  - On `OutReady`=1: IDLE, `InReady`=1, next pair accepted normally.
- **Reset mid-SHIFT:** assert `Reset` during the clamp case → next edge state IDLE.
  - All outputs 0 except `InReady`=1.
  - A fresh D=0 pair afterwards completes at its accept edge.
